// File: rtl/post_mem_arbiter.sv
// post_mem_arbiter: req/ack arbiter that shares the 1-bit tape RAM between
// the CPU (port A) and the SPI programmer (port B).
// Fixed 3-cycle access (IDLE -> ACC -> DONE). All memory-side outputs are registered.
// MODE=1 gives A priority and limits B's wait with a starvation counter.
// MODE=0 serves only B.
// Optional macro ARB_WRPROT_EN: in MODE=1, B writes are turned into reads.
// Such a write also sets the sticky PROT_ERR flag.
module post_mem_arbiter #(
  parameter int DATA_WIDTH = 1,
  parameter int ADD_WIDTH  = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  MODE,
  input  logic                  A_REQ,
  input  logic                  A_WE,
  input  logic [ADD_WIDTH-1:0]  A_ADD,
  input  logic [DATA_WIDTH-1:0] A_DIN,
  output logic [DATA_WIDTH-1:0] A_DOUT,
  output logic                  A_ACK,
  input  logic                  B_REQ,
  input  logic                  B_WE,
  input  logic [ADD_WIDTH-1:0]  B_ADD,
  input  logic [DATA_WIDTH-1:0] B_DIN,
  output logic [DATA_WIDTH-1:0] B_DOUT,
  output logic                  B_ACK,
  output logic                  M_WE,
  output logic [ADD_WIDTH-1:0]  M_ADD,
  output logic [DATA_WIDTH-1:0] M_DIN,
  input  logic [DATA_WIDTH-1:0] M_DOUT,
  output logic [1:0]            GNT,
  output logic                  PROT_ERR
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_TOP = CW'(STARVE_MAX);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

  typedef struct packed {
    logic                  we;
    logic [ADD_WIDTH-1:0]  add;
    logic [DATA_WIDTH-1:0] din;
  } req_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   starve_cnt;
  logic            b_win, grant_a, grant_b, wr_prot;
  req_t            a_req, b_req, win_req;

  assign a_req = '{we: A_WE, add: A_ADD, din: A_DIN};
  assign b_req = '{we: B_WE, add: B_ADD, din: B_DIN};

  // Next state and grant decision.
  // The winner comes from the raw REQs. A winner whose ACK is still high
  // sits out this cycle, so a continuously requesting CPU does not hand the
  // slot to B each time.
  always_comb begin
    state_d = state_q;
    b_win   = 1'b0;
    grant_a = 1'b0;
    grant_b = 1'b0;
    wr_prot = 1'b0;
    win_req = a_req;
    case (state_q)
      S_IDLE: begin
        b_win   = MODE ? (B_REQ && (!A_REQ || starve_cnt == STARVE_TOP)) : B_REQ;
        grant_b = b_win && !B_ACK;
        grant_a = MODE && A_REQ && !b_win && !A_ACK;
        if (grant_a || grant_b) state_d = S_ACC;
      end
      S_ACC:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifdef ARB_WRPROT_EN
    wr_prot = grant_b && MODE && B_WE;
`endif
    if (grant_b) begin
      win_req    = b_req;
      win_req.we = B_WE && !wr_prot;
    end
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Memory-side registers, owner tracking, read-data return and ACK pulses.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      M_WE   <= 1'b0;
      M_ADD  <= '0;
      M_DIN  <= '0;
      GNT    <= 2'b00;
      A_DOUT <= '0;
      B_DOUT <= '0;
      A_ACK  <= 1'b0;
      B_ACK  <= 1'b0;
    end else begin
      A_ACK <= 1'b0;
      B_ACK <= 1'b0;
      case (state_q)
        S_IDLE: if (grant_a || grant_b) begin
          M_WE  <= win_req.we;
          M_ADD <= win_req.add;
          M_DIN <= win_req.din;
          GNT   <= grant_b ? 2'b10 : 2'b01;
        end
        S_ACC: M_WE <= 1'b0;
        S_DONE: begin
          if (GNT[1]) begin
            B_DOUT <= M_DOUT;
            B_ACK  <= 1'b1;
          end else begin
            A_DOUT <= M_DOUT;
            A_ACK  <= 1'b1;
          end
          GNT <= 2'b00;
        end
        default: M_WE <= 1'b0;
      endcase
    end
  end

  // Starvation counter.
  // It counts A grants taken while B waits, and clears once B is served or stops asking.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                                     starve_cnt <= '0;
    else if (!B_REQ || grant_b)                  starve_cnt <= '0;
    else if (grant_a && starve_cnt != STARVE_TOP) starve_cnt <= starve_cnt + 1'b1;
  end

`ifdef ARB_WRPROT_EN
  // Sticky flag set when a blocked B write is issued; only reset clears it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)          PROT_ERR <= 1'b0;
    else if (wr_prot) PROT_ERR <= 1'b1;
  end
`else
  assign PROT_ERR = 1'b0;
`endif

endmodule
